// File: rtl/setmem_mul_pkg.sv
// setmem_mul_pkg: shared types for setmem_mul_pipe.
// Stage limits, stage payload struct, saturation helper.
package setmem_mul_pkg;

  localparam int MUL_MAX_STAGE = 8;
  localparam int MUL_MIN_STAGE = 1;
  localparam int MUL_MAX_W     = 64;
  localparam int MUL_XW        = MUL_MAX_W + 1;

  // Operands are held already sign/zero
  // extended to MUL_MAX_W by sign_mode.
  typedef struct packed {
    logic [MUL_MAX_W-1:0] op0;
    logic [MUL_MAX_W-1:0] op1;
    logic                 sign_mode;
    logic                 acc_en;
    logic                 acc_clr;
    logic                 valid;
  } mul_stage_t;

  typedef struct packed {
    logic [MUL_MAX_W-1:0] val;
    logic                 hit;
  } mul_sat_t;

  // v is an exact value, extended per sgn.
  // Clamp into a w-bit signed/unsigned range.
  function automatic mul_sat_t mul_sat(
    input logic [MUL_XW-1:0] v,
    input logic              sgn,
    input int unsigned       w
  );
    mul_sat_t                 r;
    logic signed [MUL_XW-1:0] sv;
    logic signed [MUL_XW-1:0] smax;
    logic signed [MUL_XW-1:0] smin;
    logic        [MUL_XW-1:0] umax;
    sv   = $signed(v);
    smax = (65'sd1 <<< (w - 1)) - 65'sd1;
    smin = -(65'sd1 <<< (w - 1));
    umax = (65'd1 << w) - 65'd1;
    r.val = v[MUL_MAX_W-1:0];
    r.hit = 1'b0;
    if (sgn) begin
      if (sv > smax) begin
        r.val = smax[MUL_MAX_W-1:0];
        r.hit = 1'b1;
      end else if (sv < smin) begin
        r.val = smin[MUL_MAX_W-1:0];
        r.hit = 1'b1;
      end
    end else if (v > umax) begin
      r.val = umax[MUL_MAX_W-1:0];
      r.hit = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/setmem_mul_stage_reg.sv
// setmem_mul_stage_reg: one ce-gated payload register.
// clk, rst_n (async low), ce, d -> q.
import setmem_mul_pkg::*;

module setmem_mul_stage_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  mul_stage_t d,
  output mul_stage_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/setmem_mul_pipe.sv
// setmem_mul_pipe: pipelined mul/MAC, NUM_STAGE deep, ce stall.
// Ports: clk, reset(async low), ce, in_valid, sign_mode, acc_en,
// acc_clr, din0, din1 -> dout, out_valid, busy
// (+ sat_flag when SETMEM_MUL_SAT_EN is defined: saturate).
import setmem_mul_pkg::*;

module setmem_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  sign_mode,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_valid,
`ifdef SETMEM_MUL_SAT_EN
  output logic                  busy,
  output logic                  sat_flag
`else
  output logic                  busy
`endif
);

  localparam int P  = din0_WIDTH + din1_WIDTH;
  localparam int WD = dout_WIDTH;
  localparam int N  = NUM_STAGE;
  localparam int X0 = MUL_MAX_W - din0_WIDTH;
  localparam int X1 = MUL_MAX_W - din1_WIDTH;

  if (NUM_STAGE < MUL_MIN_STAGE ||
      NUM_STAGE > MUL_MAX_STAGE) begin : g_bad_ns
    $error("setmem_mul_pipe: NUM_STAGE out of 1..8");
  end
  if (WD > P) begin : g_bad_wd
    $error("setmem_mul_pipe: dout_WIDTH too wide");
  end
  if (P > MUL_MAX_W) begin : g_bad_p
    $error("setmem_mul_pipe: operands too wide");
  end

  mul_stage_t s_in;
  mul_stage_t pl [N];
  mul_stage_t fin;

  always_comb begin
    s_in = '0;
    s_in.valid     = in_valid;
    s_in.sign_mode = sign_mode;
    s_in.acc_en    = in_valid & acc_en;
    s_in.acc_clr   = in_valid & acc_clr;
    s_in.op0 = sign_mode
      ? {{X0{din0[din0_WIDTH-1]}}, din0}
      : {{X0{1'b0}}, din0};
    s_in.op1 = sign_mode
      ? {{X1{din1[din1_WIDTH-1]}}, din1}
      : {{X1{1'b0}}, din1};
  end

  assign pl[0] = s_in;

  for (genvar i = 1; i < N; i++) begin : g_stg
    setmem_mul_stage_reg u_stg (
      .clk   (clk),
      .rst_n (reset),
      .ce    (ce),
      .d     (pl[i-1]),
      .q     (pl[i])
    );
  end

  assign fin = pl[N-1];

  // Low P bits of the extended operands'
  // product equal the exact full product.
  logic [P-1:0]  prod_full;
  logic [WD-1:0] prod_d;
  logic [WD-1:0] sum_d;
  logic [WD-1:0] acc_q;
  logic [WD-1:0] acc_nx;
  logic [WD-1:0] res;
  logic          acc_we;
  logic          prod_hit;
  logic          sum_hit;
  logic          res_hit;

  assign prod_full = fin.op0[P-1:0] * fin.op1[P-1:0];

`ifdef SETMEM_MUL_SAT_EN
  logic [WD:0]       sum_x;
  logic [MUL_XW-1:0] px;
  logic [MUL_XW-1:0] sx;
  mul_sat_t          ps;
  mul_sat_t          ss;

  always_comb begin
    if (fin.sign_mode) begin
      px = MUL_XW'($signed(prod_full));
    end else begin
      px = MUL_XW'(prod_full);
    end
    ps       = mul_sat(px, fin.sign_mode, WD);
    prod_d   = ps.val[WD-1:0];
    prod_hit = ps.hit;
    if (fin.sign_mode) begin
      sum_x = {acc_q[WD-1], acc_q}
            + {prod_d[WD-1], prod_d};
      sx    = MUL_XW'($signed(sum_x));
    end else begin
      sum_x = {1'b0, acc_q} + {1'b0, prod_d};
      sx    = MUL_XW'(sum_x);
    end
    ss      = mul_sat(sx, fin.sign_mode, WD);
    sum_d   = ss.val[WD-1:0];
    sum_hit = prod_hit | ss.hit;
  end
`else
  always_comb begin
    prod_d   = prod_full[WD-1:0];
    sum_d    = acc_q + prod_d;
    prod_hit = 1'b0;
    sum_hit  = 1'b0;
  end
`endif

  logic sel_idle;
  logic sel_mul;
  logic sel_clr;
  logic sel_acc;

  assign sel_idle = ~fin.valid;
  assign sel_mul  = fin.valid & ~fin.acc_en;
  assign sel_clr  = fin.valid & fin.acc_en
                  & fin.acc_clr;
  assign sel_acc  = fin.valid & fin.acc_en
                  & ~fin.acc_clr;

  always_comb begin
    res     = dout;
    acc_nx  = acc_q;
    acc_we  = 1'b0;
    res_hit = 1'b0;
    unique case (1'b1)
      sel_idle: ;
      sel_mul: begin
        res     = prod_d;
        res_hit = prod_hit;
      end
      sel_clr: begin
        res     = prod_d;
        res_hit = prod_hit;
        acc_nx  = prod_d;
        acc_we  = 1'b1;
      end
      sel_acc: begin
        res     = sum_d;
        res_hit = sum_hit;
        acc_nx  = sum_d;
        acc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout      <= '0;
      out_valid <= 1'b0;
      acc_q     <= '0;
    end else if (ce) begin
      dout      <= res;
      out_valid <= fin.valid;
      if (acc_we) begin
        acc_q <= acc_nx;
      end
    end
  end

`ifdef SETMEM_MUL_SAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
    end else if (ce) begin
      sat_flag <= fin.valid & res_hit;
    end
  end
`endif

  always_comb begin
    busy = out_valid;
    for (int i = 1; i < N; i++) begin
      busy = busy | pl[i].valid;
    end
  end

endmodule

// File: tb/tb_setmem_mul_pipe.sv
// tb_setmem_mul_pipe: four setmem_mul_pipe configurations
// driven in lockstep and checked against a behavioural model.
module tb_setmem_mul_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic        sign_mode = 1'b0;
  logic        acc_en = 1'b0;
  logic        acc_clr = 1'b0;
  logic [31:0] din0 = '0;
  logic [31:0] din1 = '0;
  logic [31:0] d2, d4;
  logic [25:0] d1, d8;
  logic [3:0]  ov, bz;
  logic [3:0]  sf;
  logic [63:0] dv [4];
  bit          run = 1'b0;
  int          npass = 0;
  int          ntot = 0;
  int          log4[$];
  int          exp_mac[5] = '{6, 26, 16, 9, 17};

  always #5 clk = ~clk;

  setmem_mul_pipe #(.ID(2), .NUM_STAGE(2)) u2 (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .sign_mode(sign_mode),
    .acc_en(acc_en), .acc_clr(acc_clr),
    .din0(din0), .din1(din1), .dout(d2),
    .out_valid(ov[0]), .busy(bz[0])
`ifdef SETMEM_MUL_SAT_EN
    , .sat_flag(sf[0])
`endif
  );

  setmem_mul_pipe #(.ID(4), .NUM_STAGE(4)) u4 (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .sign_mode(sign_mode),
    .acc_en(acc_en), .acc_clr(acc_clr),
    .din0(din0), .din1(din1), .dout(d4),
    .out_valid(ov[1]), .busy(bz[1])
`ifdef SETMEM_MUL_SAT_EN
    , .sat_flag(sf[1])
`endif
  );

  setmem_mul_pipe #(.ID(1), .NUM_STAGE(1),
    .din0_WIDTH(14), .din1_WIDTH(12),
    .dout_WIDTH(26)) u1 (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .sign_mode(sign_mode),
    .acc_en(acc_en), .acc_clr(acc_clr),
    .din0(din0[13:0]), .din1(din1[11:0]),
    .dout(d1), .out_valid(ov[2]), .busy(bz[2])
`ifdef SETMEM_MUL_SAT_EN
    , .sat_flag(sf[2])
`endif
  );

  setmem_mul_pipe #(.ID(8), .NUM_STAGE(8),
    .din0_WIDTH(14), .din1_WIDTH(12),
    .dout_WIDTH(26)) u8 (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .sign_mode(sign_mode),
    .acc_en(acc_en), .acc_clr(acc_clr),
    .din0(din0[13:0]), .din1(din1[11:0]),
    .dout(d8), .out_valid(ov[3]), .busy(bz[3])
`ifdef SETMEM_MUL_SAT_EN
    , .sat_flag(sf[3])
`endif
  );

`ifndef SETMEM_MUL_SAT_EN
  assign sf = '0;
`endif

  assign dv[0] = {32'h0, d2};
  assign dv[1] = {32'h0, d4};
  assign dv[2] = {38'h0, d1};
  assign dv[3] = {38'h0, d8};

  // ---------------- reference model ----------------
  function automatic int ns_of(int k);
    case (k)
      0: return 2;
      1: return 4;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int w0_of(int k);
    return (k < 2) ? 32 : 14;
  endfunction

  function automatic int w1_of(int k);
    return (k < 2) ? 32 : 12;
  endfunction

  function automatic int wd_of(int k);
    return (k < 2) ? 32 : 26;
  endfunction

  function automatic logic [63:0] mask64(int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Numeric value of a w-bit pattern.
  function automatic logic signed [127:0] to_val(
    input logic [63:0] p, input int w, input bit s);
    logic signed [127:0] r;
    logic [63:0] m;
    m = p & mask64(w);
    r = m;
    if (s && m[w-1]) r = r - (128'sd1 <<< w);
    return r;
  endfunction

  // Bring an exact value into w bits.
  function automatic logic [63:0] fit(
    input logic signed [127:0] v, input int w,
    input bit s, output bit hit);
    logic signed [127:0] lo, hi;
    hit = 1'b0;
`ifdef SETMEM_MUL_SAT_EN
    if (s) begin
      hi = (128'sd1 <<< (w - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (w - 1));
    end else begin
      hi = (128'sd1 <<< w) - 128'sd1;
      lo = 128'sd0;
    end
    if (v > hi) begin
      v = hi;
      hit = 1'b1;
    end else if (v < lo) begin
      v = lo;
      hit = 1'b1;
    end
`else
    lo = 128'sd0;
    hi = 128'sd0;
`endif
    return v[63:0] & mask64(w);
  endfunction

  typedef struct {
    logic [63:0] val;
    bit          sat;
  } exp_t;

  exp_t        pend[int];
  logic [63:0] macc[4];
  logic [63:0] exp_dout[4];
  bit          exp_ov[4];
  bit          exp_sat[4];
  int          infl[4];
  int          cnt = 0;

  initial begin
    for (int k = 0; k < 4; k++) begin
      macc[k] = '0;
      exp_dout[k] = '0;
      exp_ov[k] = 1'b0;
      exp_sat[k] = 1'b0;
      infl[k] = 0;
    end
  end

  function automatic int key(int k, int c);
    return k * 1000000 + c;
  endfunction

  task automatic mdl(input int k, output exp_t e);
    logic signed [127:0] a, b;
    logic [63:0] p;
    bit h1, h2;
    int wd;
    wd = wd_of(k);
    a = to_val({32'h0, din0}, w0_of(k), sign_mode);
    b = to_val({32'h0, din1}, w1_of(k), sign_mode);
    p = fit(a * b, wd, sign_mode, h1);
    h2 = 1'b0;
    if (!acc_en) begin
      e.val = p;
    end else if (acc_clr) begin
      macc[k] = p;
      e.val = p;
    end else begin
      macc[k] = fit(to_val(macc[k], wd, sign_mode)
                  + to_val(p, wd, sign_mode),
                    wd, sign_mode, h2);
      e.val = macc[k];
    end
    e.sat = h1 | h2;
  endtask

  // Result of a transaction issued at ce-edge c
  // is presented at ce-edge c+NUM_STAGE-1.
  always @(posedge clk or negedge reset) begin
    exp_t e;
    if (!reset) begin
      pend.delete();
      for (int k = 0; k < 4; k++) begin
        macc[k] = '0;
        exp_dout[k] = '0;
        exp_ov[k] = 1'b0;
        exp_sat[k] = 1'b0;
        infl[k] = 0;
      end
    end else if (ce) begin
      cnt++;
      for (int k = 0; k < 4; k++) begin
        if (in_valid) begin
          mdl(k, e);
          pend[key(k, cnt + ns_of(k) - 1)] = e;
          infl[k]++;
        end
        if (pend.exists(key(k, cnt))) begin
          e = pend[key(k, cnt)];
          pend.delete(key(k, cnt));
          infl[k]--;
          exp_ov[k] = 1'b1;
          exp_dout[k] = e.val;
          exp_sat[k] = e.sat;
        end else begin
          exp_ov[k] = 1'b0;
          exp_sat[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int k,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s[u%0d] got %h want %h",
                  nm, k, act, exp);
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 4; k++) begin
        chk("out_valid", k, {63'h0, ov[k]},
            {63'h0, exp_ov[k]});
        chk("dout", k, dv[k], exp_dout[k]);
        chk("busy", k, {63'h0, bz[k]},
            {63'h0, exp_ov[k] || infl[k] != 0});
`ifdef SETMEM_MUL_SAT_EN
        chk("sat_flag", k, {63'h0, sf[k]},
            {63'h0, exp_sat[k]});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (ov[1]) log4.push_back(int'(d4));
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit s, input bit ae,
                       input bit ac,
                       input logic [31:0] a,
                       input logic [31:0] b);
    ce = 1'b1;
    in_valid = 1'b1;
    sign_mode = s;
    acc_en = ae;
    acc_clr = ac;
    din0 = a;
    din1 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_en = 1'b0;
    acc_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    ce = 1'b1;
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] pool [8] = '{32'h0, 32'h1, 32'hFFFFFFFF,
    32'h7FFFFFFF, 32'h80000000, 32'h00002000,
    32'h00000800, 32'h00001FFF};

  initial begin
    #2 reset = 1'b0;
    #1 run = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // latency, signed 7 x -3
    issue(1, 0, 0, 32'd7, 32'hFFFFFFFD);
    chk("lat_early", 0, {63'h0, ov[0]}, 64'd0);
    chk("ns1_ov", 2, {63'h0, ov[2]}, 64'd1);
    chk("ns1_dout", 2, {38'h0, d1}, 64'h3FFFFEB);
    @(posedge clk);
    #1;
    chk("lat_ov", 0, {63'h0, ov[0]}, 64'd1);
    chk("lat_dout", 0, {32'h0, d2}, 64'hFFFFFFEB);
    idle(10);

    // unsigned wrap / clamp
    issue(0, 0, 0, 32'hFFFFFFFF, 32'd2);
    idle(1);
`ifdef SETMEM_MUL_SAT_EN
    chk("uns_dout", 0, {32'h0, d2}, 64'hFFFFFFFF);
    chk("uns_sat", 0, {63'h0, sf[0]}, 64'd1);
`else
    chk("uns_dout", 0, {32'h0, d2}, 64'hFFFFFFFE);
`endif
    idle(10);

    // stall with a result presented
    issue(0, 0, 0, 32'd2, 32'd2);
    issue(0, 0, 0, 32'd3, 32'd3);
    chk("stall_pre", 0, {32'h0, d2}, 64'd4);
    ce = 1'b0;
    in_valid = 1'b1;
    din0 = 32'd100;
    din1 = 32'd100;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("stall_dout", 0, {32'h0, d2}, 64'd4);
      chk("stall_ov", 0, {63'h0, ov[0]}, 64'd1);
    end
    issue(0, 0, 0, 32'd4, 32'd4);
    chk("resume_b", 0, {32'h0, d2}, 64'd9);
    @(posedge clk);
    #1;
    chk("resume_c", 0, {32'h0, d2}, 64'd16);
    chk("resume_cv", 0, {63'h0, ov[0]}, 64'd1);
    @(posedge clk);
    #1;
    chk("resume_end", 0, {63'h0, ov[0]}, 64'd0);
    idle(12);

    // MAC sequence on the 4-stage unit
    log4.delete();
    issue(0, 1, 1, 32'd2, 32'd3);
    issue(0, 1, 0, 32'd4, 32'd5);
    issue(1, 1, 0, 32'hFFFFFFFF, 32'd10);
    issue(0, 0, 0, 32'd3, 32'd3);
    issue(0, 1, 0, 32'd1, 32'd1);
    idle(12);
    chk("mac_n", 1, 64'(log4.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("mac_seq", 1, 64'(log4[i]),
          64'(exp_mac[i]));
    end

    // reset with work in flight
    log4.delete();
    issue(0, 1, 0, 32'd1, 32'd1);
    issue(0, 1, 0, 32'd1, 32'd1);
    issue(0, 1, 0, 32'd1, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_dout", 0, {32'h0, d2}, 64'd0);
    chk("rst_ov", 0, {63'h0, ov[0]}, 64'd0);
    chk("rst_busy", 1, {63'h0, bz[1]}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(12);
    chk("rst_nopulse", 1, 64'(log4.size()), 64'd0);
    issue(0, 1, 0, 32'd5, 32'd5);
    idle(6);
    chk("rst_acc_n", 1, 64'(log4.size()), 64'd1);
    if (log4.size() > 0)
      chk("rst_acc", 1, 64'(log4[0]), 64'd25);

    // mixed random traffic
    repeat (300) begin
      ce = ($urandom_range(0, 4) != 0);
      in_valid = $urandom_range(0, 1);
      sign_mode = $urandom_range(0, 1);
      acc_en = $urandom_range(0, 1);
      acc_clr = ($urandom_range(0, 3) == 0);
      din0 = $urandom_range(0, 1)
           ? $urandom : pool[$urandom_range(0, 7)];
      din1 = $urandom_range(0, 1)
           ? $urandom : pool[$urandom_range(0, 7)];
      @(posedge clk);
      #1;
    end
    acc_en = 1'b0;
    acc_clr = 1'b0;
    idle(12);

    run = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
